// File: rtl/panel_pkg.sv
// ============================================================================
//  Module      : panel_pkg
//  Description : Shared encodings, limits and reset values for the front-panel
//                menu controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package panel_pkg;

    // Parameter selected by the menu
    localparam logic [1:0] ITEM_REF  = 2'd0;
    localparam logic [1:0] ITEM_TC   = 2'd1;
    localparam logic [1:0] ITEM_SENS = 2'd2;
    localparam logic [1:0] ITEM_MODE = 2'd3;

    localparam logic [7:0] REF_MAX  = 8'd255;
    localparam logic [3:0] TC_MAX   = 4'd11;
    localparam logic [3:0] SENS_MAX = 4'd9;

    localparam logic [7:0] REF_RST  = 8'h40;
    localparam logic [3:0] TC_RST   = 4'd6;
    localparam logic [3:0] SENS_RST = 4'd9;

    localparam logic [0:0] ST_BROWSE = 1'b0;
    localparam logic [0:0] ST_EDIT   = 1'b1;

    // Bit positions of the buttons in the debounced press vector
    localparam int BTN_MENU  = 0;
    localparam int BTN_SET   = 1;
    localparam int BTN_PLUS  = 2;
    localparam int BTN_MINUS = 3;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_SET   = 3'd1,
        EV_MENU  = 3'd2,
        EV_PLUS  = 3'd3,
        EV_MINUS = 3'd4
    } event_t;

    function automatic logic [7:0] item_max(input logic [1:0] item);
        case (item)
            ITEM_REF:  item_max = REF_MAX;
            ITEM_TC:   item_max = {4'd0, TC_MAX};
            ITEM_SENS: item_max = {4'd0, SENS_MAX};
            default:   item_max = 8'd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/panel_menu_ctrl_if.sv
// ============================================================================
//  Module      : panel_menu_ctrl_if
//  Description : Panel-side bundle: raw buttons in, LEDs and committed
//                measurement configuration out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface panel_menu_ctrl_if;

    logic       MENU;
    logic       SET;
    logic       PLUS;
    logic       MINUS;
    logic       L0;
    logic       L1;
    logic       L2;
    logic       L3;
    logic [7:0] REF_IDX;
    logic [3:0] TC_IDX;
    logic [3:0] SENS_IDX;
    logic       OUT_RTHETA;
    logic       CFG_STB;

    // master: the menu controller; slave: the board / panel side
    modport master (
        input  MENU, SET, PLUS, MINUS,
        output L0, L1, L2, L3,
        output REF_IDX, TC_IDX, SENS_IDX, OUT_RTHETA, CFG_STB
    );

    modport slave (
        output MENU, SET, PLUS, MINUS,
        input  L0, L1, L2, L3,
        input  REF_IDX, TC_IDX, SENS_IDX, OUT_RTHETA, CFG_STB
    );

endinterface

`default_nettype wire

// File: rtl/panel_debounce.sv
// ============================================================================
//  Module      : panel_debounce
//  Description : One active-low button: 2-FF synchronizer, stable-state
//                debouncer and one-cycle press pulse on released->pressed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 360000
) (
    input  wire logic CLK36,
    input  wire logic RST_N,
    input  wire logic i_btn_n,
    output logic      o_press
);

    localparam int                 c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_q;
    logic               r_fall;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differ;

    assign w_differ = r_sync2 ^ r_stable;

    // The fall detector and output stage give a fixed two-cycle tail after
    // the debounced state flips.
    always_ff @(posedge CLK36 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_q <= 1'b1;
            r_fall     <= 1'b0;
            r_cnt      <= '0;
            o_press    <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_stable_q <= r_stable;
            r_fall     <= r_stable_q & ~r_stable;
            o_press    <= r_fall;
        end
    end

endmodule

`default_nettype wire

// File: rtl/panel_menu_ctrl.sv
// ============================================================================
//  Module      : panel_menu_ctrl
//  Description : Front-panel browse/edit menu: button arbitration, edit FSM,
//                shadow/commit registers, edit timeout and LED drive.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module panel_menu_ctrl
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int BLINK_BITS      = 22,
    parameter int EDIT_TIMEOUT    = 360000000
) (
    input  wire logic          CLK36,
    input  wire logic          RST_N,
    panel_menu_ctrl_if.master  pnl
);

    localparam int                 c_tmo_w   = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(EDIT_TIMEOUT - 1);

    logic [3:0]          w_btn_n;
    logic [3:0]          w_press;
    event_t              w_event;
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [1:0]          r_item;
    logic [7:0]          r_shadow;
    logic [7:0]          w_shadow_inc;
    logic [7:0]          w_shadow_dec;
    logic [7:0]          w_committed;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                w_tmo_hit;
    logic                w_commit;
    logic [BLINK_BITS:0] r_blink;
    logic [3:0]          w_led;
    logic [7:0]          r_ref;
    logic [3:0]          r_tc;
    logic [3:0]          r_sens;
    logic                r_mode;
    logic                r_cfg_stb;

    assign w_btn_n = {pnl.MINUS, pnl.PLUS, pnl.SET, pnl.MENU};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            panel_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .CLK36   (CLK36),
                .RST_N   (RST_N),
                .i_btn_n (w_btn_n[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    // Coincident presses: only the highest-priority one survives
    always_comb begin
        w_event = EV_NONE;
        if (w_press[BTN_SET])        w_event = EV_SET;
        else if (w_press[BTN_MENU])  w_event = EV_MENU;
        else if (w_press[BTN_PLUS])  w_event = EV_PLUS;
        else if (w_press[BTN_MINUS]) w_event = EV_MINUS;
    end

    // A real event in the expiry cycle takes precedence over the timeout
    assign w_tmo_hit = (r_tmo == c_tmo_max) && (w_event == EV_NONE);

    always_ff @(posedge CLK36 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_BROWSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BROWSE: begin
                if (w_event == EV_SET) w_state_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                if ((w_event == EV_SET) || (w_event == EV_MENU) || w_tmo_hit)
                    w_state_nxt = ST_BROWSE;
            end
            default: w_state_nxt = ST_BROWSE;
        endcase
    end

    always_comb begin
        w_led    = 4'b0000;
        w_commit = 1'b0;
        case (r_state)
            ST_BROWSE: w_led[r_item] = 1'b1;
            ST_EDIT: begin
                w_led[r_item] = r_blink[BLINK_BITS];
                w_commit      = (w_event == EV_SET);
            end
            default: w_led = 4'b0000;
        endcase
    end

    // Shadow arithmetic; the MODE item is a single bit that toggles
    always_comb begin
        w_shadow_inc = r_shadow;
        w_shadow_dec = r_shadow;
        if (r_item == ITEM_MODE) begin
            w_shadow_inc = {7'd0, ~r_shadow[0]};
            w_shadow_dec = {7'd0, ~r_shadow[0]};
        end else begin
            if (r_shadow < item_max(r_item)) w_shadow_inc = r_shadow + 8'd1;
            if (r_shadow != 8'd0)            w_shadow_dec = r_shadow - 8'd1;
        end
    end

    always_comb begin
        case (r_item)
            ITEM_REF:  w_committed = r_ref;
            ITEM_TC:   w_committed = {4'd0, r_tc};
            ITEM_SENS: w_committed = {4'd0, r_sens};
            default:   w_committed = {7'd0, r_mode};
        endcase
    end

    always_ff @(posedge CLK36 or negedge RST_N) begin
        if (!RST_N) begin
            r_item    <= ITEM_REF;
            r_shadow  <= 8'd0;
            r_tmo     <= '0;
            r_blink   <= '0;
            r_ref     <= REF_RST;
            r_tc      <= TC_RST;
            r_sens    <= SENS_RST;
            r_mode    <= 1'b0;
            r_cfg_stb <= 1'b0;
        end else begin
            r_blink   <= r_blink + 1'b1;
            r_cfg_stb <= w_commit;

            if ((r_state == ST_EDIT) && (w_event == EV_NONE) && !w_tmo_hit)
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;

            if (r_state == ST_BROWSE) begin
                if (w_event == EV_MENU) r_item   <= r_item + 2'd1;
                if (w_event == EV_SET)  r_shadow <= w_committed;
            end else begin
                if (w_event == EV_PLUS)  r_shadow <= w_shadow_inc;
                if (w_event == EV_MINUS) r_shadow <= w_shadow_dec;
            end

            if (w_commit) begin
                case (r_item)
                    ITEM_REF:  r_ref  <= r_shadow;
                    ITEM_TC:   r_tc   <= r_shadow[3:0];
                    ITEM_SENS: r_sens <= r_shadow[3:0];
                    default:   r_mode <= r_shadow[0];
                endcase
            end
        end
    end

    assign pnl.L0         = w_led[0];
    assign pnl.L1         = w_led[1];
    assign pnl.L2         = w_led[2];
    assign pnl.L3         = w_led[3];
    assign pnl.REF_IDX    = r_ref;
    assign pnl.TC_IDX     = r_tc;
    assign pnl.SENS_IDX   = r_sens;
    assign pnl.OUT_RTHETA = r_mode;
    assign pnl.CFG_STB    = r_cfg_stb;

endmodule

`default_nettype wire

// File: tb/tb_panel_menu_ctrl.sv
// ============================================================================
//  Module      : tb_panel_menu_ctrl
//  Description : Self-checking bench for panel_menu_ctrl against a menu-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_panel_menu_ctrl;

    localparam int D   = 4;
    localparam int BB  = 3;
    localparam int TMO = 50;

    // Press mask bits: 0 MENU, 1 SET, 2 PLUS, 3 MINUS
    localparam logic [3:0] K_MENU  = 4'b0001;
    localparam logic [3:0] K_SET   = 4'b0010;
    localparam logic [3:0] K_PLUS  = 4'b0100;
    localparam logic [3:0] K_MINUS = 4'b1000;

    logic CLK36 = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK36 = ~CLK36;

    panel_menu_ctrl_if pif ();

    panel_menu_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .BLINK_BITS      (BB),
        .EDIT_TIMEOUT    (TMO)
    ) dut (
        .CLK36 (CLK36),
        .RST_N (RST_N),
        .pnl   (pif)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int stb_seen = 0;
    int last_ev  = 0;

    // Menu-level reference model
    bit m_edit;
    int m_item;
    int m_shadow;
    int m_cfg [4];
    int m_stb_total = 0;
    int c_max [4] = '{255, 11, 9, 1};

    // Clock edges since reset release, used to predict the blink phase
    always @(posedge CLK36 or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge CLK36) begin
        if (pif.CFG_STB === 1'b1) stb_seen <= stb_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_edit   = 1'b0;
        m_item   = 0;
        m_shadow = 0;
        m_cfg    = '{64, 6, 9, 0};
    endtask

    task automatic model_event(input logic [3:0] mask, output bit stb);
        stb = 1'b0;
        if (mask[1]) begin
            if (!m_edit) begin
                m_shadow = m_cfg[m_item];
                m_edit   = 1'b1;
            end else begin
                m_cfg[m_item] = m_shadow;
                m_edit        = 1'b0;
                stb           = 1'b1;
            end
        end else if (mask[0]) begin
            if (!m_edit) m_item = (m_item + 1) % 4;
            else         m_edit = 1'b0;
        end else if (mask[2] && m_edit) begin
            if (m_item == 3)                     m_shadow = 1 - m_shadow;
            else if (m_shadow < c_max[m_item])   m_shadow = m_shadow + 1;
        end else if (mask[3] && m_edit) begin
            if (m_item == 3)                     m_shadow = 1 - m_shadow;
            else if (m_shadow > 0)               m_shadow = m_shadow - 1;
        end
    endtask

    function automatic logic [3:0] exp_led();
        logic [3:0] l;
        l = 4'b0000;
        l[m_item] = m_edit ? cyc[BB] : 1'b1;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".led"},  32'({pif.L3, pif.L2, pif.L1, pif.L0}), 32'(exp_led()));
        chk({tag, ".ref"},  32'(pif.REF_IDX),    m_cfg[0]);
        chk({tag, ".tc"},   32'(pif.TC_IDX),     m_cfg[1]);
        chk({tag, ".sens"}, 32'(pif.SENS_IDX),   m_cfg[2]);
        chk({tag, ".mode"}, 32'(pif.OUT_RTHETA), m_cfg[3]);
    endtask

    task automatic drive(input logic [3:0] mask);
        pif.MENU  = ~mask[0];
        pif.SET   = ~mask[1];
        pif.PLUS  = ~mask[2];
        pif.MINUS = ~mask[3];
    endtask

    // Called at a negedge. The press takes effect on the (D+4)th edge after
    // the first low sample, with any strobe in the following cycle only.
    task automatic press(input logic [3:0] mask, input string tag);
        bit stb;
        drive(mask);
        repeat (D + 4) @(negedge CLK36);
        chk_state({tag, ".pre"});
        chk({tag, ".stb_pre"}, 32'(pif.CFG_STB), 32'd0);
        model_event(mask, stb);
        @(negedge CLK36);
        last_ev = cyc;
        chk_state({tag, ".post"});
        chk({tag, ".stb"}, 32'(pif.CFG_STB), 32'(stb));
        m_stb_total += int'(stb);
        @(negedge CLK36);
        chk({tag, ".stb_end"}, 32'(pif.CFG_STB), 32'd0);
        drive(4'b0000);
        repeat (D + 6) @(negedge CLK36);
    endtask

    // Low for D-1 samples: must never register
    task automatic glitch(input logic [3:0] mask);
        drive(mask);
        repeat (D - 1) @(negedge CLK36);
        drive(4'b0000);
    endtask

    initial begin
        logic [3:0] mask;
        drive(4'b0000);
        model_reset();

        repeat (3) @(negedge CLK36);
        chk_state("reset");
        chk("reset.stb", 32'(pif.CFG_STB), 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK36);
            chk_state("idle");
            chk("idle.stb", 32'(pif.CFG_STB), 32'd0);
        end

        glitch(K_MINUS);
        press(K_MENU, "menu_item1");

        press(K_SET, "tc_enter");
        for (int i = 0; i < 14; i++) press(K_PLUS, "tc_plus");
        press(K_SET, "tc_commit");
        repeat (12) @(negedge CLK36);
        chk_state("tc_steady");

        press(K_MENU, "to_sens");
        press(K_MENU, "to_mode");
        press(K_SET,   "mode_enter");
        press(K_MINUS, "mode_minus");
        press(K_MENU,  "mode_cancel");
        press(K_SET,   "mode_enter2");
        glitch(K_PLUS);
        press(K_MINUS, "mode_minus2");
        press(K_SET,   "mode_commit");

        press(K_MENU, "to_ref");
        press(K_SET,  "ref_enter");
        press(K_SET | K_PLUS, "ref_set_plus");

        press(K_MENU, "to_tc");
        press(K_MENU, "to_sens2");
        press(K_SET,   "sens_enter");
        press(K_MINUS, "sens_minus");
        while (cyc < last_ev + TMO - 1) @(negedge CLK36);
        chk_state("tmo_last_edit");
        @(negedge CLK36);
        m_edit = 1'b0;
        chk_state("tmo_cancel");
        repeat (20) @(negedge CLK36);
        chk_state("tmo_after");

        press(K_SET, "sens_enter2");
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk_state("async_reset");
        chk("async_reset.stb", 32'(pif.CFG_STB), 32'd0);
        @(negedge CLK36);
        @(negedge CLK36);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK36);
        chk_state("after_reset");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0)
                mask = 4'(1 << $urandom_range(0, 3));
            else
                mask = 4'($urandom_range(1, 15));
            press(mask, "rand");
        end

        repeat (5) @(negedge CLK36);
        chk("stb_total", 32'(stb_seen), 32'(m_stb_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/panel_menu_ctrl.md
# panel_menu_ctrl

Front-panel controller for the lock-in amplifier board. It debounces the four active-low push buttons (MENU, SET, PLUS, MINUS) and runs a browse/edit menu state machine. The state machine holds the committed measurement configuration: reference-frequency index, time-constant index, sensitivity index and output mode. It drives the four panel LEDs to show the selected item and the edit state, and it strobes configuration changes to the reference generator and demodulator.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 360000, consecutive stable cycles before a button change is accepted (10 ms at 36 MHz)
- BLINK_BITS, 22, LED blink half-period is 2^BLINK_BITS cycles
- EDIT_TIMEOUT, 360000000, idle cycles in EDIT before an automatic cancel (10 s)

Ports:
- CLK36  in  1  system clock, 36 MHz; the only clock
- RST_N  in  1  asynchronous, active-low reset
- MENU, SET, PLUS, MINUS  in  1 each  raw buttons, active low, asynchronous to CLK36
- L0, L1, L2, L3  out  1 each  panel LEDs, active high
- REF_IDX  out  8  committed reference-frequency index
- TC_IDX  out  4  committed time-constant index, range 0..11
- SENS_IDX  out  4  committed sensitivity index, range 0..9
- OUT_RTHETA  out  1  committed output mode: 0 = X/Y, 1 = R/theta
- CFG_STB  out  1  one-cycle pulse after any commit

## Operation
- Per button: 2-FF synchronizer, then a stable-state debouncer, then a press detector.
  - The press detector emits a one-cycle pulse on each debounced released→pressed transition.
  - Releases produce no event. There is no auto-repeat.
- Event arbitration: if pulses coincide in one cycle, only the highest-priority one is processed and the others are dropped. Priority is SET > MENU > PLUS > MINUS.
- Item index ITEM (2 bits) selects the parameter: 0 REF, 1 TC, 2 SENS, 3 MODE.
- FSM states: BROWSE, EDIT.
- BROWSE:
  - MENU: ITEM ← ITEM+1, wrapping 3→0.
  - SET: load SHADOW from the committed value of ITEM, clear the timeout counter, go to EDIT.
  - PLUS, MINUS: ignored.
- EDIT:
  - PLUS: SHADOW+1, saturating at the item maximum (REF 255, TC 11, SENS 9).
  - MINUS: SHADOW−1, saturating at 0.
  - MODE item: PLUS or MINUS toggles SHADOW.
  - SET: commit SHADOW to the selected output, pulse CFG_STB, go to BROWSE.
  - MENU: discard SHADOW and go to BROWSE. No strobe; ITEM is unchanged.
  - Any accepted event clears the timeout counter. When the counter reaches EDIT_TIMEOUT−1, the controller cancels exactly as for MENU.
- A commit of a value equal to the current value still pulses CFG_STB.
- LEDs:
  - BROWSE: one-hot on ITEM, with L0 for item 0 through L3 for item 3.
  - EDIT: the ITEM LED blinks with the free-running blink counter's MSB; the other LEDs are off.

## Timing
- Reset values (async, immediate):
  - State BROWSE, ITEM 0, L0=1, L1=L2=L3=0.
  - REF_IDX=0x40, TC_IDX=6, SENS_IDX=9, OUT_RTHETA=0, CFG_STB=0.
  - All synchronizers and debounced states at released (1); all counters 0.
- Debounce:
  - The counter increments while the synchronized input differs from the debounced state, and clears otherwise.
  - The debounced state flips when the counter reaches DEBOUNCE_CYCLES−1 with the input still differing.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Press latency: from the first clock edge that samples a held button low to the press pulse is exactly DEBOUNCE_CYCLES+3 cycles.
- Event processing:
  - A press pulse in cycle c updates FSM, ITEM, SHADOW and LEDs at the end of cycle c.
  - On commit, the output registers update at the end of c and CFG_STB is high for cycle c+1 only.
- Outputs change only on commit or reset.
- A button held through reset release is seen as a press after debounce, at latency DEBOUNCE_CYCLES+3 from the first post-reset edge.
- Reset asserted during EDIT discards SHADOW; outputs return to their reset values.

## Structure
- Package panel_pkg holds:
  - item encodings ITEM_REF, ITEM_TC, ITEM_SENS, ITEM_MODE
  - maxima REF_MAX=255, TC_MAX=11, SENS_MAX=9
  - reset values REF_RST=0x40, TC_RST=6, SENS_RST=9
  - the FSM state encoding
- Sub-module panel_debounce: one button, comprising synchronizer, debounce counter and press-pulse output. It takes parameter DEBOUNCE_CYCLES and is instantiated four times.
- The top level holds the arbiter, FSM, shadow/commit registers, timeout counter and LED logic.

## Test plan
Use DEBOUNCE_CYCLES=4, BLINK_BITS=3 and EDIT_TIMEOUT=50 in the bench.
- Reset then idle → L0=1, L1..L3=0, REF_IDX=0x40, TC_IDX=6, SENS_IDX=9, OUT_RTHETA=0, and CFG_STB never high.
- MINUS low for 3 cycles, then MENU held low → no event from the MINUS glitch. A single MENU press pulse arrives exactly 7 cycles after the first low sample; ITEM=1 and L1 lights.
- MENU, SET, then 14 PLUS presses, then SET → TC_IDX saturates at 11, CFG_STB high for exactly 1 cycle, and the FSM returns to BROWSE with L1 steady.
- 3×MENU (MODE), SET, MINUS, MENU → OUT_RTHETA stays 0 with no strobe. Repeat, ending with SET instead → OUT_RTHETA=1 and one strobe.
- In EDIT on REF, SET and PLUS pulses in the same cycle → SET wins: REF_IDX commits unchanged (0x40) and CFG_STB pulses.
- Enter EDIT on SENS, press MINUS, then idle 50 cycles → auto-cancel, SENS_IDX stays 9. Then assert RST_N low mid-EDIT → all outputs return to their reset values immediately, asynchronously.
